mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-input muxed resource (e.g. a memory or bus port)
//  among 4 requesters. Registers a one-hot grant and drives the 2-bit select of the mux4.
//  Ownership is held until the resource signals completion.
//  Sits between requesting units and the shared mux4/resource.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles a grant is held without done (used only with ARB_TIMEOUT_EN); >=1
// PORTS
//  clk      in   1  clock, all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   4  request per requester, level; bit i = requester i
//  done     in   1  1-cycle pulse from resource: current transaction complete
//  gnt      out  4  registered one-hot grant; all-zero = no owner
//  sel      out  2  registered mux select = index of granted requester
//  busy     out  1  registered; 1 while any grant is active
//  timeout  out  1  registered 1-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, count=0.
//  - Applies mid-grant: next edge yields the reset values, with no completion required.
//  - ptr is the highest-priority index for the next decision.
//  Arbitration: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first asserted req wins.
//  - Winner w updates the registers at that edge: gnt=1<<w, sel=w, busy=1, state=GRANT.
//  - ptr is not updated until release.
//  States:
//   IDLE : req==0 -> stay IDLE. Any req -> arbitrate; GRANT next cycle (1-cycle req->gnt latency).
//   GRANT: gnt/sel held stable until release. Release = done=1 (or forced timeout).
//  On release, ptr := (w+1) mod 4.
//  - Same edge: re-arbitrate with the new ptr over the current req.
//  - Any winner: back-to-back grant, no idle gap.
//  - No winner: gnt=0, busy=0, state=IDLE.
//  Boundary rules:
//   - Winner drops req mid-grant: grant held until done.
//   - done while IDLE: ignored.
//   - done coincident with new reqs: the just-released requester has lowest priority.
//   - sel keeps the last granted index while IDLE (mux input stays stable). sel=0 only after reset.
//   - Ptr wrap: w=3 -> ptr=0.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - count clears on every new grant and increments each GRANT cycle.
//   - If count==TIMEOUT_CYCLES-1 and done=0: forced release, same rules as done.
//     * timeout=1 for the following cycle.
//   - gnt therefore stays high for exactly TIMEOUT_CYCLES cycles.
//   - done on that same cycle: normal release, no timeout pulse.
//  ARB_TIMEOUT_EN undefined:
//   - No counter logic; timeout tied 0.
//   - Grant held indefinitely until done or rst.
// TESTING
//  1 rst=1 then req=4'b0000 for 5 cycles -> gnt=0, sel=0, busy=0, timeout=0 throughout.
//  2 req=4'b0100 at cycle 0 -> cycle 1 gnt=4'b0100, sel=2, busy=1; done pulse at cycle 4 -> cycle 5 gnt=0, busy=0, sel=2.
//  3 req=4'b1111 held, done every 3rd grant cycle -> grant sequence 0,1,2,3,0, gnt never 0 between grants.
//  4 owner=1, req=4'b1010, done=1 -> next cycle gnt=4'b1000, sel=3 (requester 1 deprioritised).
//  5 gnt=4'b0010 then rst=1 one cycle, req=4'b1111 -> gnt=0 after rst edge, then gnt=4'b0001 (ptr reset).
//  6 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req=4'b0001, done=0 -> gnt high 4 cycles, then gnt re-grants 0001 with timeout=1 for 1 cycle;
//    without macro -> gnt=4'b0001 for 100 cycles, timeout=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for a shared 4-input muxed resource.
// The registered one-hot grant and the matching 2-bit mux select are held until the resource reports done.
// Optional build macro ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES grant cycles without done.
module mux4_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       forced;
    logic       release_now;
    logic [1:0] base;
    logic       found;
    logic [1:0] winner;

    // A timeout shorter than one cycle has no meaning, so reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mux4_rr_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // A forced release fires on the last allowed grant cycle; a done on that cycle wins instead.
    assign forced = (state == GRANT) && !done && (count == CW'(TIMEOUT_CYCLES - 1));
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_now = (state == GRANT) && (done || forced);

    // On release the scan starts just past the outgoing owner, so it ends up with lowest priority.
    assign base = release_now ? (sel + 2'd1) : ptr;

    // Scan base, base+1, base+2, base+3; iterating downwards lets the closest requester overwrite.
    always_comb begin
        found  = 1'b0;
        winner = base;
        for (int i = 3; i >= 0; i--) begin
            if (req[base + 2'(i)]) begin
                found  = 1'b1;
                winner = base + 2'(i);
            end
        end
    end

    // Ownership state machine: grant from IDLE, hold in GRANT, re-arbitrate on the release edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            busy  <= 1'b0;
            ptr   <= 2'd0;
        end else begin
            if (release_now) begin
                ptr <= sel + 2'd1;
            end
            if ((state == IDLE) || release_now) begin
                if (found) begin
                    gnt   <= 4'b0001 << winner;
                    sel   <= winner;
                    busy  <= 1'b1;
                    state <= GRANT;
                end else begin
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Grant-age counter restarts with every new owner and the timeout flag pulses after a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= forced;
            if (found && ((state == IDLE) || release_now)) begin
                count <= '0;
            end else if (state == GRANT) begin
                count <= count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of mux4_rr_arbiter with hand-computed expected values.
// Exercises the ARB_TIMEOUT_EN path when that macro is defined, otherwise the indefinite hold.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int num_checks;
    int num_fails;

    mux4_rr_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .timeout(timeout)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v, input logic done_v);
        rst  = rst_v;
        req  = req_v;
        done = done_v;
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios; outputs are sampled 1 time unit after each rising edge.
    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        req        = 4'b0000;
        done       = 1'b0;
        num_checks = 0;
        num_fails  = 0;

        // Reset and idle with no requests
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("rst_gnt", 8'(gnt), 8'h00);
        checkOutput("rst_sel", 8'(sel), 8'h00);
        checkOutput("rst_busy", 8'(busy), 8'h00);
        checkOutput("rst_timeout", 8'(timeout), 8'h00);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'b0000, 1'b0);
            checkOutput("idle_gnt", 8'(gnt), 8'h00);
            checkOutput("idle_sel", 8'(sel), 8'h00);
            checkOutput("idle_busy", 8'(busy), 8'h00);
            checkOutput("idle_timeout", 8'(timeout), 8'h00);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_done_gnt", 8'(gnt), 8'h00);
        checkOutput("idle_done_busy", 8'(busy), 8'h00);

        // Single requester 2, drops its request mid-grant, done at cycle 4
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("r2_c1_gnt", 8'(gnt), 8'h04);
        checkOutput("r2_c1_sel", 8'(sel), 8'h02);
        checkOutput("r2_c1_busy", 8'(busy), 8'h01);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("r2_c2_gnt", 8'(gnt), 8'h04);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("r2_c3_gnt_held", 8'(gnt), 8'h04);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("r2_c4_gnt_held", 8'(gnt), 8'h04);
        checkOutput("r2_c4_busy", 8'(busy), 8'h01);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("r2_c5_gnt", 8'(gnt), 8'h00);
        checkOutput("r2_c5_busy", 8'(busy), 8'h00);
        checkOutput("r2_c5_sel", 8'(sel), 8'h02);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("r2_idle_sel_kept", 8'(sel), 8'h02);

        // All requesting, done every third grant cycle: owners 0,1,2,3,0 back to back
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput("rr_gnt", 8'(gnt), 8'(4'b0001 << (g % 4)));
                checkOutput("rr_sel", 8'(sel), 8'(g % 4));
                checkOutput("rr_busy", 8'(busy), 8'h01);
                applyStimulus(1'b0, 4'b1111, (c == 2));
            end
        end
        checkOutput("rr_after_gnt", 8'(gnt), 8'h02);

        // Owner 1 releases while 1 and 3 request: 3 wins
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("depri_gnt", 8'(gnt), 8'h08);
        checkOutput("depri_sel", 8'(sel), 8'h03);

        // Build up ptr=2 while owner is 1, then reset must restore ptr to 0
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("wrap_gnt", 8'(gnt), 8'h02);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("regrant_gnt", 8'(gnt), 8'h02);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("midrst_gnt", 8'(gnt), 8'h00);
        checkOutput("midrst_sel", 8'(sel), 8'h00);
        checkOutput("midrst_busy", 8'(busy), 8'h00);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("postrst_gnt", 8'(gnt), 8'h01);
        checkOutput("postrst_sel", 8'(sel), 8'h00);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 4 cycles without done, then done on the last cycle suppresses the pulse
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("to_c1_gnt", 8'(gnt), 8'h01);
        checkOutput("to_c1_timeout", 8'(timeout), 8'h00);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1'b0, 4'b0001, 1'b0);
            checkOutput("to_hold_gnt", 8'(gnt), 8'h01);
            checkOutput("to_hold_timeout", 8'(timeout), 8'h00);
        end
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("to_c5_gnt", 8'(gnt), 8'h01);
        checkOutput("to_c5_timeout", 8'(timeout), 8'h01);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("to_c6_timeout", 8'(timeout), 8'h00);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("to_c8_timeout", 8'(timeout), 8'h00);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("to_done_gnt", 8'(gnt), 8'h01);
        checkOutput("to_done_timeout", 8'(timeout), 8'h00);
`else
        // Without the timeout option the grant is held indefinitely
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 4'b0001, 1'b0);
            checkOutput("hold_gnt", 8'(gnt), 8'h01);
            checkOutput("hold_timeout", 8'(timeout), 8'h00);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
